// File: rtl/square_wave_gen_pkg.sv
// -----------------------------------------------------------------------------
// square_wave_gen_pkg
// Shared definitions for the square-wave generator and its measurement-side
// counterpart: FSM state encoding and default parameter values.
// -----------------------------------------------------------------------------
package square_wave_gen_pkg;

  // Encoding is shared with the measurement block; keep the values fixed.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } sqw_state_t;

  localparam int unsigned SQW_CNT_W_DEF      = 32;
  localparam int unsigned SQW_MIN_PERIOD_DEF = 2;

endpackage : square_wave_gen_pkg

// File: rtl/square_wave_ch.sv
// -----------------------------------------------------------------------------
// square_wave_ch
// One output channel: a wrap-around counter, a high-time compare and the
// registered output pin.
//
// Ports
//   sys_clk    in   1      clock
//   sys_rst_n  in   1      synchronous reset, active low
//   period     in   CNT_W  active period; counter wraps from period-1 to 0
//   high       in   CNT_W  active high time; wave = (cnt < high)
//   start      in   CNT_W  value loaded into the counter when load is high
//   load       in   1      restart the counter at start (has priority)
//   enable     in   1      count and drive the pin; when low the pin is 0
//   cnt        out  CNT_W  current counter value
//   wave       out  1      registered output, one cycle behind cnt
// -----------------------------------------------------------------------------
module square_wave_ch
  import square_wave_gen_pkg::*;
#(
  parameter int unsigned CNT_W = SQW_CNT_W_DEF
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] high,
  input  logic [CNT_W-1:0] start,
  input  logic             load,
  input  logic             enable,
  output logic [CNT_W-1:0] cnt,
  output logic             wave
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_reg;
  logic             wave_reg;
  logic             at_end;

  // ">=" rather than "==" so the counter can never run past the period,
  // even if a load ever placed it out of range.
  assign at_end = (cnt_reg >= period - ONE);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      cnt_reg  <= '0;
      wave_reg <= 1'b0;
    end else begin
      // The pin reflects the counter value of the cycle just ending, so a
      // load on the last cycle of a period still finishes the old waveform.
      wave_reg <= enable && (cnt_reg < high);
      if (load) begin
        cnt_reg <= start;
      end else if (enable) begin
        cnt_reg <= at_end ? '0 : cnt_reg + ONE;
      end
    end
  end

  assign cnt  = cnt_reg;
  assign wave = wave_reg;

endmodule : square_wave_ch

// File: rtl/square_wave_gen.sv
// -----------------------------------------------------------------------------
// square_wave_gen
// Two-channel programmable square-wave generator. Period, high time and the
// ch1 phase lead arrive over a valid/ready config port; accepted settings are
// held as pending and only committed at a period boundary (or immediately
// when idle), so the outputs never glitch. f_out = SYS_CLK_FREQ / period.
//
// Build option: define SQW_PHASE_EN to give ch1 its own counter starting at
// cfg_phase (ch1 leads ch0 by phase cycles). Without it ch1 is the
// complement of ch0 while running (0 when idle), cfg_phase is ignored and
// never causes a rejection.
//
// Ports
//   sys_clk        in   1      system clock
//   sys_rst_n      in   1      synchronous reset, active low
//   run_en         in   1      1 = generate, 0 = stop at end of current period
//   cfg_valid      in   1      config request
//   cfg_ready      out  1      config accept (transfer on valid & ready)
//   cfg_period     in   CNT_W  period in cycles
//   cfg_high       in   CNT_W  high time in cycles
//   cfg_phase      in   CNT_W  ch1 lead in cycles
//   cfg_err        out  1      one-cycle pulse: config rejected
//   wave_out       out  2      registered square-wave outputs
//   period_strobe  out  1      pulse aligned with the last cycle of a period
//   running        out  1      high while generating (RUN or DRAIN)
// -----------------------------------------------------------------------------
module square_wave_gen
  import square_wave_gen_pkg::*;
#(
  parameter int unsigned SYS_CLK_FREQ = 50_000_000,
  parameter int unsigned CNT_W        = SQW_CNT_W_DEF,
  parameter int unsigned MIN_PERIOD   = SQW_MIN_PERIOD_DEF
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             run_en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic [CNT_W-1:0] cfg_phase,
  output logic             cfg_err,
  output logic [1:0]       wave_out,
  output logic             period_strobe,
  output logic             running
);

`ifdef SQW_PHASE_EN
  localparam int NUM_CH = 2;
`else
  localparam int NUM_CH = 1;
`endif

  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_P = CNT_W'(MIN_PERIOD);

  // The clock frequency only documents the output-frequency relation.
  logic [31:0] unused_freq;
  assign unused_freq = 32'(SYS_CLK_FREQ);

  sqw_state_t       state_reg;
  logic [CNT_W-1:0] act_period_reg, act_high_reg;
  logic [CNT_W-1:0] pend_period_reg, pend_high_reg;
`ifdef SQW_PHASE_EN
  logic [CNT_W-1:0] act_phase_reg, pend_phase_reg;
`else
  logic             wave_inv_reg;
  logic             unused_phase;
  assign unused_phase = ^cfg_phase;
`endif
  logic             pend_reg, loaded_reg;
  logic             cfg_ready_reg, cfg_err_reg, strobe_reg, running_reg;

  logic [CNT_W-1:0] ch_cnt   [NUM_CH];
  logic [CNT_W-1:0] ch_start [NUM_CH];
  logic [NUM_CH-1:0] ch_wave;

  logic run_active, boundary, accept, cfg_ok, accept_ok, commit, go_run, ch_load;

  assign run_active = (state_reg != ST_IDLE);
  assign boundary   = run_active && (ch_cnt[0] == act_period_reg - ONE);
  assign accept     = cfg_valid && cfg_ready_reg;
`ifdef SQW_PHASE_EN
  assign cfg_ok     = (cfg_period >= MIN_P) && (cfg_phase < cfg_period);
`else
  assign cfg_ok     = (cfg_period >= MIN_P);
`endif
  assign accept_ok  = accept && cfg_ok;
  // pend_reg is only set by an earlier accept, so a config accepted on a
  // boundary cycle waits for the following boundary.
  assign commit     = pend_reg && (!run_active || boundary);
  assign go_run     = (state_reg == ST_IDLE) && run_en && loaded_reg;
  // Counters restart on RUN entry and on every committed reconfiguration.
  assign ch_load    = go_run || (commit && run_active);

  assign ch_start[0] = '0;
`ifdef SQW_PHASE_EN
  // On a simultaneous commit the new phase must be used straight away.
  assign ch_start[1] = commit ? pend_phase_reg : act_phase_reg;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      square_wave_ch #(.CNT_W(CNT_W)) u_ch (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .period    (act_period_reg),
        .high      (act_high_reg),
        .start     (ch_start[gi]),
        .load      (ch_load),
        .enable    (run_active),
        .cnt       (ch_cnt[gi]),
        .wave      (ch_wave[gi])
      );
      if (gi > 0) begin : g_cnt_sink
        logic unused_cnt;
        assign unused_cnt = ^ch_cnt[gi];
      end
    end
  endgenerate

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_reg       <= ST_IDLE;
      act_period_reg  <= '0;
      act_high_reg    <= '0;
      pend_period_reg <= '0;
      pend_high_reg   <= '0;
`ifdef SQW_PHASE_EN
      act_phase_reg   <= '0;
      pend_phase_reg  <= '0;
`else
      wave_inv_reg    <= 1'b0;
`endif
      pend_reg        <= 1'b0;
      loaded_reg      <= 1'b0;
      cfg_ready_reg   <= 1'b1;
      cfg_err_reg     <= 1'b0;
      strobe_reg      <= 1'b0;
      running_reg     <= 1'b0;
    end else begin
      cfg_err_reg <= accept && !cfg_ok;
      // Ready drops on accept and comes back one cycle after the commit
      // clears the pending flag.
      cfg_ready_reg <= accept_ok ? 1'b0 : !pend_reg;
      strobe_reg    <= boundary;
      // Same latency as the pins so running falls with the last output cycle.
      running_reg   <= run_active;
`ifndef SQW_PHASE_EN
      wave_inv_reg  <= run_active && !(ch_cnt[0] < act_high_reg);
`endif

      if (commit) begin
        pend_reg       <= 1'b0;
        loaded_reg     <= 1'b1;
        act_period_reg <= pend_period_reg;
        act_high_reg   <= pend_high_reg;
`ifdef SQW_PHASE_EN
        act_phase_reg  <= pend_phase_reg;
`endif
      end

      if (accept_ok) begin
        pend_reg        <= 1'b1;
        pend_period_reg <= cfg_period;
        pend_high_reg   <= cfg_high;
`ifdef SQW_PHASE_EN
        pend_phase_reg  <= cfg_phase;
`endif
      end

      case (state_reg)
        ST_IDLE: begin
          if (go_run) state_reg <= ST_RUN;
        end
        ST_RUN: begin
          if (!run_en) state_reg <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (run_en) begin
            state_reg <= ST_RUN;
          end else if (boundary) begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

`ifdef SQW_PHASE_EN
  assign wave_out = {ch_wave[1], ch_wave[0]};
`else
  assign wave_out = {wave_inv_reg, ch_wave[0]};
`endif
  assign cfg_ready     = cfg_ready_reg;
  assign cfg_err       = cfg_err_reg;
  assign period_strobe = strobe_reg;
  assign running       = running_reg;

endmodule : square_wave_gen

// File: tb/tb_square_wave_gen.sv
// -----------------------------------------------------------------------------
// tb_square_wave_gen
// Randomised bench with a scoreboard. A reference model, clocked on the rising
// edge, derives the expected outputs from a time-based view of the waveform
// (position in period = cycles since segment start modulo period) and pushes
// them into a queue; a monitor on the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_square_wave_gen;

`ifdef SQW_PHASE_EN
  localparam bit PHASE_EN = 1'b1;
`else
  localparam bit PHASE_EN = 1'b0;
`endif

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        run_en;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_period, cfg_high, cfg_phase;
  logic        cfg_err;
  logic [1:0]  wave_out;
  logic        period_strobe;
  logic        running;

  always #5 sys_clk = ~sys_clk;

  square_wave_gen #(
    .SYS_CLK_FREQ (50_000_000),
    .CNT_W        (32),
    .MIN_PERIOD   (2)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .run_en        (run_en),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_period    (cfg_period),
    .cfg_high      (cfg_high),
    .cfg_phase     (cfg_phase),
    .cfg_err       (cfg_err),
    .wave_out      (wave_out),
    .period_strobe (period_strobe),
    .running       (running)
  );

  typedef struct packed {
    logic [1:0] wave;
    logic       strobe;
    logic       running;
    logic       ready;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   done  = 1'b0;

  // ---------------- reference model ----------------
  // m_mode: 0 stopped, 1 generating, 2 finishing the current period
  longint m_cyc = 0;
  int     m_mode = 0;
  bit     m_pend = 0, m_loaded = 0, m_ready = 1;
  longint p_per = 0, p_high = 0, p_ph = 0;
  longint a_per = 0, a_high = 0, a_ph = 0;
  longint m_seg = 0;

  always @(posedge sys_clk) begin : model
    exp_t   e;
    longint pos;
    bit     gen, last, acc, ok, com, go;
    e = '0;
    if (!sys_rst_n) begin
      m_mode = 0; m_pend = 0; m_loaded = 0; m_ready = 1;
      p_per = 0; p_high = 0; p_ph = 0; a_per = 0; a_high = 0; a_ph = 0;
      e.ready = 1'b1;
    end else begin
      gen  = (m_mode != 0);
      pos  = 0;
      last = 1'b0;
      if (gen) begin
        pos  = (m_cyc - m_seg) % a_per;
        last = (pos == a_per - 1);
        e.wave[0] = (pos < a_high);
        if (PHASE_EN) e.wave[1] = (((pos + a_ph) % a_per) < a_high);
        else          e.wave[1] = !(pos < a_high);
      end
      e.strobe  = last;
      e.running = gen;
      acc = cfg_valid && m_ready;
      ok  = (cfg_period >= 2) && (!PHASE_EN || (cfg_phase < cfg_period));
      e.err = acc && !ok;
      com = m_pend && (!gen || last);
      go  = (m_mode == 0) && run_en && m_loaded;

      if (com) begin
        a_per = p_per; a_high = p_high; a_ph = p_ph;
        m_loaded = 1;
        m_pend = 0;
        if (gen) m_seg = m_cyc + 1;
      end
      if (acc && ok) begin
        m_pend = 1;
        p_per = cfg_period; p_high = cfg_high; p_ph = cfg_phase;
      end
      // Ready is low while something is pending and on the commit cycle.
      m_ready = !(m_pend || com);
      e.ready = m_ready;

      case (m_mode)
        0: if (go) begin m_mode = 1; m_seg = m_cyc + 1; end
        1: if (!run_en) m_mode = 2;
        default: begin
          if (run_en) m_mode = 1;
          else if (last) m_mode = 0;
        end
      endcase
    end
    exp_q.push_back(e);
    m_cyc++;
  end

  // ---------------- monitor ----------------
  task automatic chk(input string nm, input logic [1:0] got, input logic [1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s at %0t: got=%b expected=%b", nm, $time, got, want);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge sys_clk);
      if (done) break;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wave_out", wave_out, e.wave);
        chk("period_strobe", {1'b0, period_strobe}, {1'b0, e.strobe});
        chk("running", {1'b0, running}, {1'b0, e.running});
        chk("cfg_ready", {1'b0, cfg_ready}, {1'b0, e.ready});
        chk("cfg_err", {1'b0, cfg_err}, {1'b0, e.err});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic send_cfg(input int p, input int h, input int ph);
    int waited = 0;
    cfg_period = p;
    cfg_high   = h;
    cfg_phase  = ph;
    cfg_valid  = 1'b1;
    while (!cfg_ready && waited < 100) begin
      @(negedge sys_clk);
      waited++;
    end
    total++;
    if (!cfg_ready) begin
      bad++;
      $display("FAIL cfg_handshake at %0t: cfg_ready=%b after %0d cycles, expected 1", $time, cfg_ready, waited);
    end
    @(negedge sys_clk);
    cfg_valid = 1'b0;
    $display("cfg period=%0d high=%0d phase=%0d waited=%0d", p, h, ph, waited);
  endtask

  initial begin : stimulus
    int r;
    sys_rst_n = 1'b0; run_en = 1'b0; cfg_valid = 1'b0;
    cfg_period = '0; cfg_high = '0; cfg_phase = '0;
    tick(3);
    sys_rst_n = 1'b1;
    tick(2);

    run_en = 1'b1;
    send_cfg(10, 3, 0);  tick(35);          // basic 3/7 waveform
    send_cfg(1, 1, 0);   tick(3);           // period below minimum
    send_cfg(10, 4, 12); tick(5);           // phase >= period
    send_cfg(10, 3, 0);  tick(14);
    send_cfg(4, 2, 0);   tick(20);          // reconfigure mid-period
    send_cfg(10, 0, 0);  tick(15);          // constant 0
    send_cfg(10, 10, 0); tick(25);          // constant 1
    send_cfg(2, 1, 0);   tick(10);          // toggle every cycle
    send_cfg(10, 3, 0);  tick(16);
    run_en = 1'b0; tick(15);                // drain to idle
    run_en = 1'b1; tick(12);
    run_en = 1'b0; tick(3);
    run_en = 1'b1; tick(20);                // re-arm during drain
    send_cfg(8, 4, 2);   tick(24);          // phase lead
    sys_rst_n = 1'b0; tick(1);              // reset mid-run
    sys_rst_n = 1'b1; tick(3);
    send_cfg(6, 2, 1);   tick(20);

    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 9));
      case (r)
        0, 1, 2, 3: tick(int'($urandom_range(1, 15)));
        4, 5:       begin run_en = ~run_en; tick(1); end
        6, 7:       send_cfg(int'($urandom_range(2, 12)), int'($urandom_range(0, 13)),
                             int'($urandom_range(0, 11)));
        8:          send_cfg(int'($urandom_range(0, 12)), int'($urandom_range(0, 13)),
                             int'($urandom_range(0, 13)));
        default: begin
          if ($urandom_range(0, 3) == 0) begin
            sys_rst_n = 1'b0; tick(2); sys_rst_n = 1'b1;
          end
          tick(1);
        end
      endcase
    end

    tick(2);
    done = 1'b1;
    tick(1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_square_wave_gen
